hazard_forward_unit: RTL
========================

Name: hazard_forward_unit

Overview:
Parametrised successor to the EX-stage forwarding logic. It adds a per-register load scoreboard that drives a load-use stall to the ID stage, and supports a configurable load latency. It forwards into NUM_SRC execute operands and into the MEM-stage store data. It sits between ID/EX/MEM/WB pipeline registers and the hazard/stall control of the core.

Parameters:
XLEN, 64, operand/data width
NUM_SRC, 2, number of EX source operands forwarded (≥1)
REG_AW, 5, register address width (2**REG_AW architectural regs, reg 0 hardwired zero)
LOAD_LAT, 1, bubbles a dependent must wait after a load issues (1 = classic 5-stage)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_id_valid  in  1  valid instruction in ID
i_id_rs  in  NUM_SRC*REG_AW  ID source regs, slot k at [k*REG_AW +: REG_AW]
i_id_rs_used  in  NUM_SRC  ID slot k actually read
i_id_rd  in  REG_AW  ID destination
i_id_rd_we  in  1  ID writes rd
i_id_is_load  in  1  ID instruction is a load
i_idex_rs  in  NUM_SRC*REG_AW  EX source regs
i_idex_rs_value  in  NUM_SRC*XLEN  regfile values latched in ID/EX
i_exmem_rd  in  REG_AW  MEM-stage rd
i_exmem_we  in  1  MEM-stage writes rd
i_exmem_rd_value  in  XLEN  MEM-stage ALU result
i_exmem_rs2  in  REG_AW  MEM-stage store source reg
i_exmem_rs2_value  in  XLEN  MEM-stage store data
i_exmem_mem_write  in  1  MEM-stage is a store
i_memwb_rd  in  REG_AW  WB rd
i_memwb_we  in  1  WB writes rd
i_memwb_rd_value  in  XLEN  WB ALU result
i_memwb_mem_data  in  XLEN  WB load data
i_memwb_mem_to_reg  in  1  WB is a load
o_stall  out  1  hold IF/ID, inject bubble into EX
o_exe_rs_value  out  NUM_SRC*XLEN  forwarded EX operands
o_fwd_sel  out  NUM_SRC*2  per slot: 0 regfile, 1 EX/MEM, 2 MEM/WB
o_mem_rs2_value  out  XLEN  forwarded store data
o_stall_count  out  32  stall-cycle counter (optional feature)

Behaviour:
- Clock i_clk; reset i_rst synchronous, active-high.
- Scoreboard: one counter per reg, width clog2(LOAD_LAT+1); reset → all 0, so o_stall=0 the cycle after reset.
- issue = i_id_valid & ~o_stall. On issue & i_id_is_load & i_id_rd_we & i_id_rd≠0: cnt[i_id_rd] ← LOAD_LAT.
- On issue & ~i_id_is_load & i_id_rd_we: cnt[i_id_rd] ← 0 (younger ALU write supersedes the pending load).
- All other nonzero counters decrement by 1 every cycle, including stall cycles. Set/clear takes priority over decrement for the same reg.
- o_stall (combinational from registered state) = i_id_valid & OR over k of (i_id_rs_used[k] & rs_k≠0 & cnt[rs_k]≠0).
- Dependent load issued at cycle T stalls exactly LOAD_LAT cycles. Multiple pending loads are tracked independently.
- Operand mux per slot k (combinational, zero latency). rs=0 → regfile value, sel 0.
  - Priority 1: i_exmem_we & i_exmem_rd==rs → EX/MEM value, sel 1.
  - Priority 2: i_memwb_we & i_memwb_rd==rs → (mem_to_reg ? mem_data : rd_value), sel 2.
  - Otherwise regfile value, sel 0.
- Store data: i_exmem_mem_write & i_memwb_we & i_memwb_mem_to_reg & i_memwb_rd==i_exmem_rs2 & rs2≠0 → i_memwb_mem_data; else i_exmem_rs2_value.
- Reset mid-stall: counters cleared the next edge and stall drops; in-flight pipeline state is the caller's concern.

Optional Feature:
HAZARD_PERF_CNT_EN defined: o_stall_count increments each cycle o_stall=1, saturates at 0xFFFFFFFF, reset to 0. Not defined: no counter flops; o_stall_count tied to 0.

Test Plan:
- LOAD_LAT=1: load x5 issues, next ID reads x5 → o_stall=1 for 1 cycle; dependent then gets i_memwb_mem_data (0xDEAD) with sel 2.
- LOAD_LAT=3: same sequence → exactly 3 stall cycles. With HAZARD_PERF_CNT_EN, o_stall_count=3.
- EX/MEM and MEM/WB both write x7 (0x11 vs 0x22), EX reads x7 in both slots → both slots 0x11, sel 1.
- x0 in EX/MEM with we=1 and value 0x55 → operand stays regfile 0, sel 0; load to x0 causes no stall.
- Load x4 then ALU writes x4 on the next issue → subsequent reader of x4 does not stall.
- Load x9 in WB (data 0xBEEF), store in MEM with rs2=x9 → o_mem_rs2_value=0xBEEF. Same case with rs2=x8 → i_exmem_rs2_value.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// EX/MEM-stage operand forwarding plus a per-register load scoreboard that stalls ID on load-use.
// Optional stall-cycle counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_forward_unit #(
    parameter int XLEN     = 64,
    parameter int NUM_SRC  = 2,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   i_id_rs,
    input  logic [NUM_SRC-1:0]          i_id_rs_used,
    input  logic [REG_AW-1:0]           i_id_rd,
    input  logic                        i_id_rd_we,
    input  logic                        i_id_is_load,
    input  logic [NUM_SRC*REG_AW-1:0]   i_idex_rs,
    input  logic [NUM_SRC*XLEN-1:0]     i_idex_rs_value,
    input  logic [REG_AW-1:0]           i_exmem_rd,
    input  logic                        i_exmem_we,
    input  logic [XLEN-1:0]             i_exmem_rd_value,
    input  logic [REG_AW-1:0]           i_exmem_rs2,
    input  logic [XLEN-1:0]             i_exmem_rs2_value,
    input  logic                        i_exmem_mem_write,
    input  logic [REG_AW-1:0]           i_memwb_rd,
    input  logic                        i_memwb_we,
    input  logic [XLEN-1:0]             i_memwb_rd_value,
    input  logic [XLEN-1:0]             i_memwb_mem_data,
    input  logic                        i_memwb_mem_to_reg,
    output logic                        o_stall,
    output logic [NUM_SRC*XLEN-1:0]     o_exe_rs_value,
    output logic [NUM_SRC*2-1:0]        o_fwd_sel,
    output logic [XLEN-1:0]             o_mem_rs2_value,
    output logic [31:0]                 o_stall_count
);

    localparam int NREG = 1 << REG_AW;
    localparam int CW   = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
    localparam logic [CW-1:0] LAT_INIT = CW'(LOAD_LAT);

    localparam logic [1:0] SEL_RF    = 2'd0;
    localparam logic [1:0] SEL_EXMEM = 2'd1;
    localparam logic [1:0] SEL_MEMWB = 2'd2;

    logic [CW-1:0]      cnt_q [NREG];
    logic [CW-1:0]      cnt_d [NREG];
    logic [NUM_SRC-1:0] slot_hazard;
    logic               stall;
    logic               issue;
    logic [XLEN-1:0]    wb_value;

    // ------------------------------------------------------------------
    // Load-use detection against the registered scoreboard
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_hazard
            logic [REG_AW-1:0] id_rs;
            assign id_rs           = i_id_rs[gi*REG_AW +: REG_AW];
            assign slot_hazard[gi] = i_id_rs_used[gi] & (id_rs != '0) & (cnt_q[id_rs] != '0);
        end
    endgenerate

    assign stall   = i_id_valid & (|slot_hazard);
    assign issue   = i_id_valid & ~stall;
    assign o_stall = stall;

    // Counters age every cycle; an issuing writer of the same reg overrides the aging.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - CW'(1)) : '0;
        end
        if (issue && i_id_rd_we) begin
            if (i_id_is_load) begin
                if (i_id_rd != '0) begin
                    cnt_d[i_id_rd] = LAT_INIT;
                end
            end else begin
                cnt_d[i_id_rd] = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // ------------------------------------------------------------------
    // Execute operand forwarding, youngest producer wins
    // ------------------------------------------------------------------
    assign wb_value = i_memwb_mem_to_reg ? i_memwb_mem_data : i_memwb_rd_value;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
            logic [REG_AW-1:0] ex_rs;
            logic [XLEN-1:0]   rf_value;
            logic [XLEN-1:0]   fwd_value;
            logic [1:0]        fwd_sel;

            assign ex_rs    = i_idex_rs[gi*REG_AW +: REG_AW];
            assign rf_value = i_idex_rs_value[gi*XLEN +: XLEN];

            always_comb begin
                fwd_sel   = SEL_RF;
                fwd_value = rf_value;
                if (ex_rs != '0) begin
                    if (i_exmem_we && (i_exmem_rd == ex_rs)) begin
                        fwd_sel   = SEL_EXMEM;
                        fwd_value = i_exmem_rd_value;
                    end else if (i_memwb_we && (i_memwb_rd == ex_rs)) begin
                        fwd_sel   = SEL_MEMWB;
                        fwd_value = wb_value;
                    end
                end
            end

            assign o_exe_rs_value[gi*XLEN +: XLEN] = fwd_value;
            assign o_fwd_sel[gi*2 +: 2]            = fwd_sel;
        end
    endgenerate

    // A store right behind a load of its data register picks the load data off WB.
    assign o_mem_rs2_value = (i_exmem_mem_write && i_memwb_we && i_memwb_mem_to_reg &&
                              (i_memwb_rd == i_exmem_rs2) && (i_exmem_rs2 != '0))
                             ? i_memwb_mem_data : i_exmem_rs2_value;

    // ------------------------------------------------------------------
    // Stall-cycle counter
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_count_q;
    logic [31:0] stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign o_stall_count = stall_count_q;
`else
    assign o_stall_count = 32'd0;
`endif

endmodule
